load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-side consumer of the control unit's MemWrite and funct3_o outputs. It turns one RV32I load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) into a word-aligned request on a data-memory port with a grant/response handshake. For loads it returns sign- or zero-extended data. It stalls the pipeline until the access completes and sits between the ALU result / rs2 path and data memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of addr and mem_addr.
DATA_WIDTH, 32, data width. Fixed at 32; any other value is a compile-time error.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  memory op is presented this cycle. Held stable by the pipeline while stall=1.
MemWrite  in  1  1 = store, 0 = load.
funct3  in  3  access size/sign, RV32I encoding.
addr  in  ADDR_WIDTH  byte address (ALU result).
wdata  in  32  store data (rs2).
stall  out  1  pipeline must hold the current op.
rdata  out  32  extended load result; 0 when rdata_valid=0.
rdata_valid  out  1  one-cycle pulse on load completion.
misaligned  out  1  one-cycle pulse on a misaligned address or illegal funct3.
mem_req  out  1  request to memory.
mem_we  out  1  write enable.
mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
mem_be  out  4  byte enables.
mem_wdata  out  32  lane-replicated store data.
mem_gnt  in  1  memory accepted the request.
mem_rvalid  in  1  load data valid; arrives at least 1 cycle after mem_gnt.
mem_rdata  in  32  load data word.

Behaviour:
- Reset (synchronous): state goes to IDLE and every latched field is cleared. Next cycle all outputs are 0 unless a new req_valid arrives.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - req_valid=1 with a legal, aligned op: latch MemWrite, funct3, addr, wdata; assert stall combinationally; go to REQ.
  - req_valid=1 with an illegal or misaligned op: misaligned=1 for this cycle, stall=0, no memory access, stay IDLE.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
- REQ:
  - Outputs: mem_req=1, mem_we=latched MemWrite, mem_addr={addr[31:2],2'b00}.
  - Store on mem_gnt: stall=0 this cycle, go to IDLE. Total latency is 2 cycles with immediate grant.
  - Load on mem_gnt: stall stays 1, go to WAIT.
  - No mem_gnt: hold every mem_* output stable, stall=1.
- WAIT:
  - mem_req=0; stall = ~mem_rvalid.
  - On mem_rvalid: rdata_valid=1 and rdata=extended data, both combinational in that cycle; go to IDLE.
- stall drops in the completion cycle, so the pipeline advances at that edge and the held op is never re-issued. req_valid is ignored outside IDLE.
- Store lane rules (off = addr[1:0]):
  - SB: mem_be = 4'b0001<<off; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 4'b0011<<off; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = wdata.
- Loads: mem_be=4'b1111 in REQ. Lane select uses the latched off.
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: half at off, sign/zero-extended.
  - LW: full word.
- Boundary cases:
  - mem_rvalid in IDLE or REQ is ignored.
  - rst during REQ or WAIT abandons the access; a late mem_rvalid after reset produces nothing.
  - A new req_valid in the cycle after completion is accepted normally (back-to-back ops).
- mem_* outputs are 0 whenever state≠REQ, except mem_addr, which is don't-care and driven 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum {IDLE, REQ, WAIT}.
  - lsu_op_t struct {we, funct3, addr, wdata}.
- Sub-module lsu_load_align (combinational): inputs mem_rdata, off, funct3; output is the extended 32-bit result.

Test Plan:
1. SW addr=0x100, wdata=0xDEADBEEF, mem_gnt=1 immediately → cycle1: mem_req=1, mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; stall=1 in cycle0, 0 in cycle1.
2. SB addr=0x103, wdata=0x000000A5, mem_gnt delayed 2 cycles → mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5, all held stable across the wait; stall released on the grant cycle.
3. mem_rdata=0x80FF7F00, rvalid 3 cycles after grant → LB@0x102 gives 0xFFFFFFFF; LBU@0x102 gives 0x000000FF; LH@0x102 gives 0xFFFF80FF; LHU@0x102 gives 0x000080FF; rdata_valid is a single-cycle pulse each time.
4. LW addr=0x101, and SH funct3=001 addr=0x203 → misaligned pulses 1 cycle, mem_req stays 0, stall=0; store with funct3=100 → misaligned=1.
5. LW 0x200 granted, then rst asserted in WAIT, then mem_rvalid → rdata_valid=0, stall=0, mem_req=0 after reset.
6. LW 0x300 completes, SW 0x304 presented the next cycle → second mem_req occurs exactly 1 cycle later, with no duplicate issue of the load.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_op_t;

  // Legal encoding for the direction, and natural alignment for the size.
  function automatic logic op_ok(logic we, logic [2:0] f3, logic [1:0] off);
    case (f3)
      F3_B:    op_ok = 1'b1;
      F3_BU:   op_ok = !we;
      F3_H:    op_ok = !off[0];
      F3_HU:   op_ok = !we && !off[0];
      F3_W:    op_ok = (off == 2'b00);
      default: op_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a loaded word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data_c
);

  logic [31:0] lane;

  always_comb begin
    lane   = mem_rdata >> {off, 3'b000};
    data_c = lane;
    case (funct3)
      F3_B:    data_c = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   data_c = {24'h0, lane[7:0]};
      F3_H:    data_c = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   data_c = {16'h0, lane[15:0]};
      default: data_c = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one op at a time onto a word-aligned memory port
// with grant/rvalid handshake, stalling the pipeline until completion.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("load_store_unit: DATA_WIDTH must be 32");
  end

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [1:0]  off_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign off_q = op_q.addr[1:0];

  // State and latched op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Store lane placement from the latched op
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = op_q.wdata;
    case (op_q.funct3)
      F3_B: begin
        st_be    = 4'(4'b0001 << off_q);
        st_wdata = {4{op_q.wdata[7:0]}};
      end
      F3_H: begin
        st_be    = 4'(4'b0011 << off_q);
        st_wdata = {2{op_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .funct3    (op_q.funct3),
    .data_c    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    stall       = 1'b0;
    misaligned  = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (op_ok(MemWrite, funct3, addr[1:0])) begin
            op_d.we     = MemWrite;
            op_d.funct3 = funct3;
            op_d.addr   = LSU_ADDR_W'(addr);
            op_d.wdata  = wdata;
            stall       = 1'b1;
            state_d     = REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = op_q.we;
        mem_addr  = ADDR_WIDTH'({op_q.addr[LSU_ADDR_W-1:2], 2'b00});
        mem_be    = op_q.we ? st_be : 4'b1111;
        mem_wdata = op_q.we ? st_wdata : 32'h0;
        stall     = 1'b1;
        if (mem_gnt) begin
          // Stores finish on the grant; loads wait for their data
          if (op_q.we) begin
            stall   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = ~mem_rvalid;
        if (mem_rvalid) begin
          rdata_valid = 1'b1;
          rdata       = ld_data;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory requests and load
// results are queued as stimulus is driven and popped when the DUT produces them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misaligned, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  req_t        e;
  logic        prev_rv = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_be(logic we, logic [2:0] f3, logic [1:0] off);
    if (!we) return 4'hF;
    case (f3)
      3'b000: case (off)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
              endcase
      3'b001: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(logic we, logic [2:0] f3, logic [31:0] d);
    if (!we) return 32'h0;
    case (f3)
      3'b000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    o = int'(off);
    b = w[o*8 +: 8];
    h = (o >= 2) ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100:  return {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Monitor: memory handshakes and load completions against the scoreboard
  always @(negedge clk) begin
    if (mem_req && mem_gnt) begin
      if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
      else begin
        e = req_q.pop_front();
        chk("req_we", {31'd0, mem_we}, {31'd0, e.we});
        chk("req_addr", mem_addr, e.a);
        chk("req_be", {28'd0, mem_be}, {28'd0, e.be});
        chk("req_wdata", mem_wdata, e.wd);
      end
    end
    if (rdata_valid) begin
      chk("rv_pulse", {31'd0, prev_rv}, 32'd0);
      if (ld_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
      else chk("rdata", rdata, ld_q.pop_front());
    end else if (rdata !== 32'h0) begin
      chk("rdata_idle", rdata, 32'h0);
    end
    prev_rv = rdata_valid;
  end

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gdly, input int rdly,
                       input logic [31:0] word, input logic noise);
    logic [3:0]  be;
    logic [31:0] wdx;
    be  = exp_be(we, f3, a[1:0]);
    wdx = exp_wd(we, f3, wd);
    req_valid = 1'b1; MemWrite = we; funct3 = f3; addr = a; wdata = wd;
    req_q.push_back('{we, {a[31:2], 2'b00}, be, wdx});
    @(negedge clk);
    chk("c0_stall", {31'd0, stall}, 32'd1);
    chk("c0_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < gdly; i++) begin
      mem_rvalid = noise;
      @(negedge clk);
      chk("hold_stall", {31'd0, stall}, 32'd1);
      chk("hold_mem_req", {31'd0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, {a[31:2], 2'b00});
      chk("hold_be", {28'd0, mem_be}, {28'd0, be});
      chk("hold_wdata", mem_wdata, wdx);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b1;
    @(negedge clk);
    chk("gnt_stall", {31'd0, stall}, we ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (!we) begin
      for (int i = 1; i < rdly; i++) begin
        @(negedge clk);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      ld_q.push_back(exp_ld(word, a[1:0], f3));
      @(negedge clk);
      chk("done_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  task automatic bad_op(input logic we, input logic [2:0] f3, input logic [31:0] a);
    req_valid = 1'b1; MemWrite = we; funct3 = f3; addr = a; wdata = 32'h1234_5678;
    @(negedge clk);
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_clear", {31'd0, misaligned}, 32'd0);
    chk("mis_mem_req2", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lf [4];
    lf = '{3'b000, 3'b100, 3'b001, 3'b101};
    rst = 1'b1; req_valid = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    @(posedge clk); #1;

    do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
    do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 2, 0, 32'h0, 1'b1);
    do_op(1'b1, 3'b001, 32'h202, 32'hCAFE1234, 1, 0, 32'h0, 1'b0);
    foreach (lf[i]) do_op(1'b0, lf[i], 32'h102, 32'h0, 0, 3, 32'h80FF7F00, 1'b0);
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 1, 2, 32'h1357_9BDF, 1'b0);
    do_op(1'b0, 3'b000, 32'h101, 32'h0, 0, 1, 32'h0000_7F00, 1'b0);

    bad_op(1'b0, 3'b010, 32'h101);
    bad_op(1'b1, 3'b001, 32'h203);
    bad_op(1'b1, 3'b100, 32'h200);
    bad_op(1'b0, 3'b011, 32'h000);

    // Reset while waiting for load data; the late rvalid must be dropped
    req_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h200;
    req_q.push_back('{1'b0, 32'h200, 4'hF, 32'h0});
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("post_rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // Back-to-back: load completes, store presented the very next cycle
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 1, 32'hA1B2_C3D4, 1'b0);
    do_op(1'b1, 3'b010, 32'h304, 32'h0BAD_F00D, 0, 0, 32'h0, 1'b0);

    @(negedge clk);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ld_q_empty", ld_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
